// File: rtl/fpga_mem_pkg.sv
// rtl/fpga_mem_pkg.sv - shared defaults and sizing helpers for the FPGA memory subsystem
package fpga_mem_pkg;

  localparam int unsigned DEF_NB_COL    = 4;
  localparam int unsigned DEF_COL_WIDTH = 8;
  localparam int unsigned DEF_RAM_DEPTH = 1024;

  // A single-word array would give $clog2 == 0; keep at least one address bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned col_lsb(input int unsigned col, input int unsigned width);
    return col * width;
  endfunction

  function automatic int unsigned col_msb(input int unsigned col, input int unsigned width);
    return col * width + width - 1;
  endfunction

endpackage

// File: rtl/endgenerate_ram_col.sv
// rtl/endgenerate_ram_col.sv - one byte-column storage lane of the byte-write RAM
module endgenerate_ram_col #(
  parameter int unsigned COL_WIDTH = 8,
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic                 clk_i,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [COL_WIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [COL_WIDTH-1:0] rdata
);

  // Zero image at configuration; no reset on the array so the tools map it to block RAM.
  logic [COL_WIDTH-1:0] mem [RAM_DEPTH] = '{default: '0};

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/endgenerate_ram.sv
// rtl/endgenerate_ram.sv - single-port byte-write RAM with registered read address
module endgenerate_ram
  import fpga_mem_pkg::*;
#(
  parameter int unsigned NB_COL    = DEF_NB_COL,
  parameter int unsigned COL_WIDTH = DEF_COL_WIDTH,
  parameter int unsigned RAM_DEPTH = DEF_RAM_DEPTH,
  localparam int unsigned AW        = addr_width(RAM_DEPTH),
  localparam int unsigned DataWidth = NB_COL * COL_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [NB_COL-1:0]    bwe_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam logic [AW:0] DepthW = (AW+1)'(RAM_DEPTH);

  logic          in_range;
  logic          rd_en;
  logic [AW-1:0] addr_q;

  // Only matters for non-power-of-two depths; addresses past the end are dropped.
  assign in_range = ({1'b0, addr_i} < DepthW);
  assign rd_en    = req_i && in_range && (bwe_i == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else if (rd_en) begin
      addr_q <= addr_i;
    end
  end

  for (genvar i = 0; i < NB_COL; i++) begin : g_col
    endgenerate_ram_col #(
      .COL_WIDTH (COL_WIDTH),
      .RAM_DEPTH (RAM_DEPTH),
      .AW        (AW)
    ) u_col (
      .clk_i (clk_i),
      .we    (req_i && in_range && bwe_i[i]),
      .waddr (addr_i),
      .wdata (wdata_i[col_msb(i, COL_WIDTH):col_lsb(i, COL_WIDTH)]),
      .raddr (addr_q),
      .rdata (rdata_o[col_msb(i, COL_WIDTH):col_lsb(i, COL_WIDTH)])
    );
  end

endmodule

// File: tb/tb_endgenerate_ram.sv
// tb/tb_endgenerate_ram.sv - scoreboard bench for endgenerate_ram against a word-array model
module tb_endgenerate_ram;

  localparam int unsigned NBC   = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEPTH = 1000;
  localparam int unsigned AWT   = 10;
  localparam int unsigned DW    = NBC * CW;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           req_i = 1'b0;
  logic [AWT-1:0] addr_i = '0;
  logic [DW-1:0]  wdata_i = '0;
  logic [NBC-1:0] bwe_i = '0;
  logic [DW-1:0]  rdata_o;

  endgenerate_ram #(
    .NB_COL    (NBC),
    .COL_WIDTH (CW),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .bwe_i   (bwe_i),
    .rdata_o (rdata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string         tag;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t          sb_q[$];
  event          sample_ev;
  int            n_cmp = 0;
  int            n_bad = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  int unsigned   ref_rd_addr;

  // Monitor: rdata_o is the observable response; check it shortly after each sample point.
  initial begin
    forever begin
      @(sample_ev);
      #1;
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_cmp++;
        if (rdata_o !== e.exp) begin
          n_bad++;
          $display("FAIL %s: rdata_o=%08h expected %08h", e.tag, rdata_o, e.exp);
        end
      end
    end
  end

  task automatic push_exp(input string tag, input logic [DW-1:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
    -> sample_ev;
  endtask

  // Reference behaviour of one clock edge, applied to the model state.
  task automatic ref_edge(input logic req, input int unsigned addr,
                          input logic [NBC-1:0] bwe, input logic [DW-1:0] wd);
    if (req && addr < DEPTH) begin
      for (int c = 0; c < NBC; c++) begin
        if (bwe[c]) ref_mem[addr][c*CW +: CW] = wd[c*CW +: CW];
      end
      if (bwe == 0 && rst_ni) ref_rd_addr = addr;
    end
    if (!rst_ni) ref_rd_addr = 0;
  endtask

  // One cycle: inputs set after a falling edge, expectation queued after the rising edge.
  task automatic cyc(input string tag, input logic req, input int unsigned addr,
                     input logic [NBC-1:0] bwe, input logic [DW-1:0] wd,
                     input logic use_k, input logic [DW-1:0] k);
    req_i   = req;
    addr_i  = AWT'(addr);
    bwe_i   = bwe;
    wdata_i = wd;
    @(posedge clk_i);
    ref_edge(req, addr, bwe, wd);
    push_exp(tag, use_k ? k : ref_mem[ref_rd_addr]);
    @(negedge clk_i);
  endtask

  task automatic rd(input string tag, input int unsigned a, input logic [DW-1:0] k);
    cyc(tag, 1'b1, a, '0, $urandom, 1'b1, k);
  endtask

  task automatic wr(input string tag, input int unsigned a, input logic [NBC-1:0] b,
                    input logic [DW-1:0] d, input logic [DW-1:0] k);
    cyc(tag, 1'b1, a, b, d, 1'b1, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d required 0", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    ref_rd_addr = 0;

    #3;
    push_exp("reset_state", 32'h0);
    @(negedge clk_i);
    cyc("reset_hold", 1'b0, 5, '0, 32'h0, 1'b1, 32'h0);
    rst_ni = 1'b1;
    cyc("post_reset_idle", 1'b0, 0, '0, 32'h0, 1'b1, 32'h0);

    rd("read5_init", 5, 32'h0);
    wr("write3_full_old_view", 3, 4'hF, 32'hDEADBEEF, 32'h0);
    rd("read3_full", 3, 32'hDEADBEEF);
    wr("byte_merge_through", 3, 4'b0101, 32'h11223344, 32'hDE22BE44);
    rd("read3_merge", 3, 32'hDE22BE44);

    rd("read7_init", 7, 32'h0);
    wr("write7_through", 7, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D);
    wr("write8_no_effect", 8, 4'hF, 32'h0BADC0DE, 32'hCAFEF00D);

    rd("read3_before_rst", 3, 32'hDE22BE44);
    #2;
    rst_ni = 1'b0;
    #1;
    ref_rd_addr = 0;
    push_exp("async_reset_mem0", 32'h0);
    @(negedge clk_i);
    wr("write0_in_reset", 0, 4'hF, 32'h12345678, 32'h12345678);
    rst_ni = 1'b1;
    rd("read3_retained", 3, 32'hDE22BE44);

    for (int i = 0; i < 10; i++) begin
      cyc("idle_hold", 1'b0, $urandom_range(0, 1023), NBC'($urandom), $urandom, 1'b1, 32'hDE22BE44);
    end
    rd("read8_after_idle", 8, 32'h0BADC0DE);

    wr("write_top", DEPTH - 1, 4'hF, 32'hA5A5A5A5, 32'h0BADC0DE);
    rd("read_top", DEPTH - 1, 32'hA5A5A5A5);
    rd("read0_unaffected", 0, 32'h12345678);
    wr("write_oor", DEPTH + 5, 4'hF, 32'hFFFFFFFF, 32'h12345678);
    rd("read_oor_hold", DEPTH + 5, 32'h12345678);

    for (int i = 0; i < 400; i++) begin
      int unsigned   sel;
      int unsigned   a;
      logic [NBC-1:0] b;
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = $urandom_range(0, 1023);
      else if (sel < 4)  a = $urandom_range(0, 15);
      else               a = $urandom_range(DEPTH - 10, DEPTH + 10);
      b = ($urandom_range(0, 3) < 2) ? '0 : NBC'($urandom);
      cyc("random", ($urandom_range(0, 7) != 0), a, b, $urandom, 1'b0, '0);
    end

    #3;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: pending=%0d required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/endgenerate_ram.md
Name: endgenerate_ram

Overview:
- Single-port, byte-write RAM for the FPGA memory subsystem.
- Intended for Xilinx BRAM inference and used as instruction/data SRAM behind a req/addr/wdata/be memory port.
- Writes are per byte column. A read captures the address; read data is driven combinationally from the stored address, so the output always reflects current array contents (write-first visibility).

Parameters:
- NB_COL, 4: number of byte columns per word; must be ≥1.
- COL_WIDTH, 8: bits per column (typically 8 or 9).
- RAM_DEPTH, 1024: number of words; must be ≥2. AW = $clog2(RAM_DEPTH).
- DataWidth (localparam) = NB_COL*COL_WIDTH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  access request, one per cycle.
- addr_i  in  AW  word address.
- wdata_i  in  DataWidth  write data.
- bwe_i  in  NB_COL  byte write enables; bit i covers wdata_i[i*COL_WIDTH +: COL_WIDTH].
- rdata_o  out  DataWidth  read data = MEM[addr_q].

Behaviour:
- Storage: array MEM[RAM_DEPTH] of DataWidth bits, initialised to all-zero at time zero / bitstream load. Reset does NOT clear contents.
- Write: on a rising edge with req_i=1, every column i with bwe_i[i]=1 gets MEM[addr_i][col i] <= wdata_i[col i]. Other columns are unchanged.
- Read: on a rising edge with req_i=1 and bwe_i=='0 (all enables low), addr_q <= addr_i.
- Partial or full writes do not update addr_q.
- req_i=0: no write, addr_q holds.
- rdata_o = MEM[addr_q], combinational from addr_q and array contents.
- Read latency: data for a read issued in cycle N is valid after edge N+1 and stays stable until the next read or a write to addr_q.
- A write to the word at addr_q is visible on rdata_o right after the write edge.
- Reset: asynchronous, rst_ni=0 forces addr_q=0 immediately, so rdata_o=MEM[0]. While in reset, writes are still performed if req_i&bwe_i; addr_q stays 0.
- Out-of-range address (addr_i ≥ RAM_DEPTH, non-power-of-two depth): writes are ignored and addr_q is not updated; rdata_o never indexes outside the array.
- No stall or handshake: every request is accepted in its cycle, with no ready/gnt signal.
- Coding: memory write logic in a plain clocked block with no reset, so BRAM inference is preserved. Only addr_q carries the async reset.

Decomposition:
- Shared package fpga_mem_pkg:
  - default constants (NB_COL=4, COL_WIDTH=8, RAM_DEPTH=1024);
  - function for address width;
  - helper for column slicing bounds.
- Optional sub-module endgenerate_ram_col: one byte-column write lane, instantiated NB_COL times via generate. Otherwise a single flat module is acceptable.

Test Plan:
- Reset/init: hold rst_ni=0, then release with no requests → rdata_o=0 (MEM[0] initial zero). Read addr 5 → rdata_o=0x00000000 after one edge.
- Full write then read: write addr 3, bwe=4'hF, wdata=0xDEADBEEF; next cycle read addr 3 → rdata_o=0xDEADBEEF after the read edge.
- Byte merge: addr 3 holds 0xDEADBEEF; write bwe=4'b0101, wdata=0x11223344; read addr 3 → 0xDE22BE44.
- Write-through visibility: read addr 7 (contains 0), then write addr 7 bwe=4'hF wdata=0xCAFEF00D without a new read → rdata_o becomes 0xCAFEF00D right after the write edge. Write to addr 8 → rdata_o unchanged.
- Async reset mid-operation: after reading addr 3, pull rst_ni low between clock edges → rdata_o switches to MEM[0] without a clock edge. Memory contents are retained: read addr 3 after release still returns 0xDE22BE44.
- Idle/hold: req_i=0 with arbitrary addr/bwe/wdata for 10 cycles → no memory change, rdata_o constant. Boundary: write/read addr RAM_DEPTH-1 with 0xA5A5A5A5 → read back correctly, and addr 0 is unaffected.
